// File: rtl/tcdm_bank_arbiter_pkg.sv
// Shared types and address-decode constants for the TCDM bank arbiter.
// The tile request/response structs and the bank-side request struct are defined here.
package tcdm_bank_arbiter_pkg;

  localparam int unsigned AddrWidth        = 32;
  localparam int unsigned DataWidth        = 32;
  localparam int unsigned BeWidth          = DataWidth / 8;
  localparam int unsigned ByteOffset       = $clog2(BeWidth);
  localparam int unsigned BankingFactor    = 4;
  localparam int unsigned NumBanks         = BankingFactor;
  localparam int unsigned BankIdxWidth     = $clog2(NumBanks);
  localparam int unsigned TCDMAddrMemWidth = 8;
  localparam int unsigned BankBitOffset    = ByteOffset;
  localparam int unsigned RowBitOffset     = ByteOffset + BankIdxWidth;

  typedef logic [AddrWidth-1:0]        addr_t;
  typedef logic [DataWidth-1:0]        data_t;
  typedef logic [BeWidth-1:0]          be_t;
  typedef logic [TCDMAddrMemWidth-1:0] tcdm_addr_t;
  typedef logic [BankIdxWidth-1:0]     bank_idx_t;

  typedef struct packed {
    logic  req;
    logic  we;
    addr_t addr;
    data_t wdata;
    be_t   be;
  } tile_req_t;

  typedef struct packed {
    logic  gnt;
    logic  vld;
    data_t rdata;
  } tile_resp_t;

  typedef struct packed {
    logic       req;
    logic       we;
    tcdm_addr_t addr;
    data_t      wdata;
    be_t        be;
  } tcdm_bank_req_t;

  // Higher address bits above the row field are ignored, so addresses alias.
  function automatic bank_idx_t decode_bank(input addr_t addr);
    return addr[BankBitOffset +: BankIdxWidth];
  endfunction

  function automatic tcdm_addr_t decode_row(input addr_t addr);
    return addr[RowBitOffset +: TCDMAddrMemWidth];
  endfunction

endpackage

// File: rtl/tcdm_bank_arbiter_rr.sv
// Round-robin arbiter for one TCDM bank: combinational grant, registered priority pointer.
// The winner is the first requester at or after the pointer, searching upward modulo NumReq.
module tcdm_rr_arbiter #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned ReqIdxW = $clog2(NumReq)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumReq-1:0]  i_req,
  output logic [NumReq-1:0]  o_gnt,
  output logic [ReqIdxW-1:0] o_idx,
  output logic               o_valid
);

  logic [ReqIdxW-1:0] r_ptr;
  logic [NumReq-1:0]  w_req;
  logic [ReqIdxW:0]   w_cand;

  assign w_req = rst_i ? '0 : i_req;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    o_gnt   = '0;
    w_cand  = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      w_cand = {1'b0, r_ptr} + (ReqIdxW+1)'(k);
      if (w_cand >= (ReqIdxW+1)'(NumReq)) w_cand = w_cand - (ReqIdxW+1)'(NumReq);
      if (!o_valid && w_req[w_cand[ReqIdxW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[ReqIdxW-1:0];
      end
    end
    if (o_valid) o_gnt[o_idx] = 1'b1;
  end

  // NOTE: sequential state is only ever assigned with non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (o_valid) begin
      r_ptr <= (o_idx == ReqIdxW'(NumReq - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Shares the word-interleaved TCDM banks among NumReq requesters: decode, per-bank
// round-robin arbitration, bank request muxing and one-cycle response routing.
module tcdm_bank_arbiter
  import tcdm_bank_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  tile_req_t  [NumReq-1:0]             req_i,
  output tile_resp_t [NumReq-1:0]             resp_o,
  output logic       [NumBanks-1:0]           bank_req_o,
  output logic       [NumBanks-1:0]           bank_we_o,
  output tcdm_addr_t [NumBanks-1:0]           bank_addr_o,
  output data_t      [NumBanks-1:0]           bank_wdata_o,
  output be_t        [NumBanks-1:0]           bank_be_o,
  input  data_t      [NumBanks-1:0]           bank_rdata_i
);

  localparam int unsigned ReqIdxW = $clog2(NumReq);

  logic [NumReq-1:0]  w_cand    [NumBanks];
  logic [NumReq-1:0]  w_arb_gnt [NumBanks];
  logic [ReqIdxW-1:0] w_win_idx [NumBanks];
  logic [NumBanks-1:0] w_win_vld;
  tcdm_bank_req_t     w_bank    [NumBanks];

  logic [NumBanks-1:0] r_rsp_vld;
  logic [NumBanks-1:0] r_rsp_we;
  logic [ReqIdxW-1:0]  r_rsp_id [NumBanks];

  always_comb begin
    for (int b = 0; b < int'(NumBanks); b++) begin
      w_cand[b] = '0;
      for (int r = 0; r < int'(NumReq); r++) begin
        w_cand[b][r] = req_i[r].req && (decode_bank(req_i[r].addr) == bank_idx_t'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    tcdm_rr_arbiter #(.NumReq(NumReq), .ReqIdxW(ReqIdxW)) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_req   (w_cand[b]),
      .o_gnt   (w_arb_gnt[b]),
      .o_idx   (w_win_idx[b]),
      .o_valid (w_win_vld[b])
    );
  end

  always_comb begin
    for (int b = 0; b < int'(NumBanks); b++) begin
      w_bank[b] = '0;
      if (w_win_vld[b]) begin
        w_bank[b].req   = 1'b1;
        w_bank[b].we    = req_i[w_win_idx[b]].we;
        w_bank[b].addr  = decode_row(req_i[w_win_idx[b]].addr);
        w_bank[b].wdata = req_i[w_win_idx[b]].wdata;
        w_bank[b].be    = req_i[w_win_idx[b]].be;
      end
      bank_req_o[b]   = w_bank[b].req;
      bank_we_o[b]    = w_bank[b].we;
      bank_addr_o[b]  = w_bank[b].addr;
      bank_wdata_o[b] = w_bank[b].wdata;
      bank_be_o[b]    = w_bank[b].be;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_rsp_vld <= '0;
    else       r_rsp_vld <= w_win_vld;
  end

  // NOTE: id/we are payload qualified by r_rsp_vld, so they carry no reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(NumBanks); b++) begin
      r_rsp_id[b] <= w_win_idx[b];
      r_rsp_we[b] <= w_bank[b].we;
    end
  end

  // A response pending across a reset assertion is dropped by the rst_i gate.
  always_comb begin
    for (int r = 0; r < int'(NumReq); r++) begin
      resp_o[r] = '0;
      for (int b = 0; b < int'(NumBanks); b++) begin
        if (w_arb_gnt[b][r]) resp_o[r].gnt = 1'b1;
        if (r_rsp_vld[b] && !rst_i && (r_rsp_id[b] == ReqIdxW'(r))) begin
          resp_o[r].vld = 1'b1;
          if (!r_rsp_we[b]) resp_o[r].rdata = bank_rdata_i[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter with a behavioural one-cycle SRAM per bank.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_tcdm_bank_arbiter;
  import tcdm_bank_arbiter_pkg::*;

  localparam int unsigned NumReq = 4;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  tile_req_t  [NumReq-1:0]       req_i;
  tile_resp_t [NumReq-1:0]       resp_o;
  logic       [NumBanks-1:0]     bank_req_o;
  logic       [NumBanks-1:0]     bank_we_o;
  tcdm_addr_t [NumBanks-1:0]     bank_addr_o;
  data_t      [NumBanks-1:0]     bank_wdata_o;
  be_t        [NumBanks-1:0]     bank_be_o;
  data_t      [NumBanks-1:0]     bank_rdata_i;

  int n_checks = 0;
  int n_pass   = 0;

  data_t mem [NumBanks][256];

  tcdm_bank_arbiter #(.NumReq(NumReq)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .resp_o       (resp_o),
    .bank_req_o   (bank_req_o),
    .bank_we_o    (bank_we_o),
    .bank_addr_o  (bank_addr_o),
    .bank_wdata_o (bank_wdata_o),
    .bank_be_o    (bank_be_o),
    .bank_rdata_i (bank_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Word (b,row) initially holds 32'hC0DE_0000 | b<<8 | row.
  initial begin
    bank_rdata_i = '0;
    for (int b = 0; b < int'(NumBanks); b++)
      for (int a = 0; a < 256; a++)
        mem[b][a] = 32'hC0DE_0000 | (b << 8) | a;
  end

  always @(posedge clk_i) begin
    for (int b = 0; b < int'(NumBanks); b++) begin
      if (bank_req_o[b]) begin
        if (bank_we_o[b]) begin
          for (int k = 0; k < int'(BeWidth); k++)
            if (bank_be_o[b][k]) mem[b][bank_addr_o[b]][8*k +: 8] <= bank_wdata_o[b][8*k +: 8];
        end else begin
          bank_rdata_i[b] <= mem[b][bank_addr_o[b]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [NumReq-1:0] gnt_v();
    for (int r = 0; r < int'(NumReq); r++) gnt_v[r] = resp_o[r].gnt;
  endfunction

  function automatic logic [NumReq-1:0] vld_v();
    for (int r = 0; r < int'(NumReq); r++) vld_v[r] = resp_o[r].vld;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rd(input int r, input logic [31:0] addr);
    req_i[r] = '{req: 1'b1, we: 1'b0, addr: addr, wdata: '0, be: '0};
  endtask

  task automatic idle(input int r);
    req_i[r] = '0;
  endtask

  initial begin
    req_i = '0;
    rst_i = 1'b1;
    // Reset with all four contending for bank 0.
    for (int r = 0; r < int'(NumReq); r++) rd(r, 32'h10 * r);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check("rst_gnt", 32'(gnt_v()), 32'h0);
      check("rst_bank_req", 32'(bank_req_o), 32'h0);
      check("rst_vld", 32'(vld_v()), 32'h0);
    end

    // Full contention on bank 0; each requester drops after its grant.
    tick(); rst_i = 1'b0; settle();
    check("c0_gnt", 32'(gnt_v()), 32'b0001);
    check("c0_bank_req", 32'(bank_req_o), 32'b0001);
    check("c0_row", 32'(bank_addr_o[0]), 32'd0);
    check("c0_vld", 32'(vld_v()), 32'h0);
    tick(); idle(0); settle();
    check("c1_gnt", 32'(gnt_v()), 32'b0010);
    check("c1_row", 32'(bank_addr_o[0]), 32'd1);
    check("c1_vld", 32'(vld_v()), 32'b0001);
    check("c1_rdata0", resp_o[0].rdata, 32'hC0DE_0000);
    tick(); idle(1); settle();
    check("c2_gnt", 32'(gnt_v()), 32'b0100);
    check("c2_row", 32'(bank_addr_o[0]), 32'd2);
    check("c2_vld", 32'(vld_v()), 32'b0010);
    check("c2_rdata1", resp_o[1].rdata, 32'hC0DE_0001);
    tick(); idle(2); settle();
    check("c3_gnt", 32'(gnt_v()), 32'b1000);
    check("c3_row", 32'(bank_addr_o[0]), 32'd3);
    check("c3_vld", 32'(vld_v()), 32'b0100);
    check("c3_rdata2", resp_o[2].rdata, 32'hC0DE_0002);
    tick(); idle(3); settle();
    check("c4_gnt", 32'(gnt_v()), 32'h0);
    check("c4_bank_req", 32'(bank_req_o), 32'h0);
    check("c4_vld", 32'(vld_v()), 32'b1000);
    check("c4_rdata3", resp_o[3].rdata, 32'hC0DE_0003);

    // Parallel access to four different banks.
    tick(); rd(0, 32'h0); rd(1, 32'h4); rd(2, 32'h8); rd(3, 32'hC); settle();
    check("par_gnt", 32'(gnt_v()), 32'b1111);
    check("par_bank_req", 32'(bank_req_o), 32'b1111);
    check("par_rows", {bank_addr_o[3], bank_addr_o[2], bank_addr_o[1], bank_addr_o[0]}, 32'h0);
    tick(); for (int r = 0; r < int'(NumReq); r++) idle(r); settle();
    check("par_vld", 32'(vld_v()), 32'b1111);
    check("par_rdata0", resp_o[0].rdata, 32'hC0DE_0000);
    check("par_rdata1", resp_o[1].rdata, 32'hC0DE_0100);
    check("par_rdata2", resp_o[2].rdata, 32'hC0DE_0200);
    check("par_rdata3", resp_o[3].rdata, 32'hC0DE_0300);

    // Pointer wrap on bank 2: requester 3 wins, then 0 beats 3.
    tick(); rd(3, 32'h8); settle();
    check("wrap_gnt3", 32'(gnt_v()), 32'b1000);
    tick(); rd(0, 32'h18); settle();
    check("wrap_gnt0", 32'(gnt_v()), 32'b0001);
    check("wrap_row", 32'(bank_addr_o[2]), 32'd1);
    check("wrap_vld3", 32'(vld_v()), 32'b1000);
    tick(); idle(0); settle();
    check("wrap_gnt3b", 32'(gnt_v()), 32'b1000);
    check("wrap_rdata0", resp_o[0].rdata, 32'hC0DE_0201);
    tick(); idle(3); settle();
    check("wrap_vld3b", 32'(vld_v()), 32'b1000);
    check("wrap_rdata3", resp_o[3].rdata, 32'hC0DE_0200);

    // Write then read back through bank 1, row 0x10.
    tick();
    req_i[1] = '{req: 1'b1, we: 1'b1, addr: 32'h104, wdata: 32'hDEAD_BEEF, be: 4'b1111};
    settle();
    check("wr_gnt", 32'(gnt_v()), 32'b0010);
    check("wr_bank_we", 32'(bank_we_o), 32'b0010);
    check("wr_row", 32'(bank_addr_o[1]), 32'h10);
    check("wr_wdata", bank_wdata_o[1], 32'hDEAD_BEEF);
    check("wr_be", 32'(bank_be_o[1]), 32'hF);
    tick(); rd(1, 32'h104); settle();
    check("wr_vld", 32'(vld_v()), 32'b0010);
    check("wr_rdata_zero", resp_o[1].rdata, 32'h0);
    tick(); idle(1); settle();
    check("rb_vld", 32'(vld_v()), 32'b0010);
    check("rb_rdata", resp_o[1].rdata, 32'hDEAD_BEEF);

    // A request with req=0 never wins.
    tick();
    req_i[0] = '{req: 1'b0, we: 1'b1, addr: 32'h0, wdata: 32'h1234_5678, be: 4'hF};
    settle();
    check("noreq_gnt", 32'(gnt_v()), 32'h0);
    check("noreq_bank_req", 32'(bank_req_o), 32'h0);
    check("noreq_bank_we", 32'(bank_we_o), 32'h0);

    // Reset the cycle after a grant: response dropped, pointers back to 0.
    tick(); idle(0); rd(2, 32'h8); settle();
    check("mr_gnt", 32'(gnt_v()), 32'b0100);
    tick(); idle(2); rd(0, 32'h8); rst_i = 1'b1; settle();
    check("mr_vld", 32'(vld_v()), 32'h0);
    check("mr_rdata2", resp_o[2].rdata, 32'h0);
    check("mr_gnt_rst", 32'(gnt_v()), 32'h0);
    check("mr_bank_req_rst", 32'(bank_req_o), 32'h0);
    tick(); rst_i = 1'b0; rd(0, 32'h18); rd(3, 32'h8); settle();
    check("mr_ptr_gnt", 32'(gnt_v()), 32'b0001);
    check("mr_vld_after", 32'(vld_v()), 32'h0);
    tick(); idle(0); idle(3); settle();
    check("mr_vld_resume", 32'(vld_v()), 32'b0001);
    check("mr_rdata_resume", resp_o[0].rdata, 32'hC0DE_0201);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
